kw_arb_grant_mux: RTL and testbench

- Downstream consumer of the static-priority arbiter's one-hot grant.
- Muxes N valid/ready packet streams onto one registered output stream.
- Holds ownership for a whole multi-beat packet, from grant capture to the accepted `last` beat, and drives the arbiter's lock inputs for that owner.
- Sits between N client sources and a shared downstream sink; the arbiter connects between `request`/`lock` (outputs here) and `grant` (input here).

---
 rtl/kw_arb_grant_mux.sv | 127 ++++++++++++
 tb/tb_kw_arb_grant_mux.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kw_arb_grant_mux.sv
// Packet-level grant consumer: captures a one-hot grant, then streams the owner's
// beats through a single registered output stage until its last beat is accepted.
module kw_arb_grant_mux #(
  parameter int N     = 4,
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [N-1:0]       request,
  output logic [N-1:0]       lock,
  input  logic [N-1:0]       grant,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [N-1:0]       owner,
  output logic               busy,
  output logic               grant_err
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       owner_q, owner_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               grant_err_q, grant_err_d;

  logic [WIDTH-1:0]   masked_data [N];
  logic [WIDTH-1:0]   sel_data;
  logic               owner_valid;
  logic               owner_last;
  logic               in_pkt;
  logic               can_accept;
  logic               load;
  logic               grant_multi;
  logic               grant_onehot;

  // AND-OR mux keyed by the one-hot owner; non-owners contribute zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked_data[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{owner_q[gi]}};
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  assign owner_valid  = |(owner_q & in_valid);
  assign owner_last   = |(owner_q & in_last);
  assign in_pkt       = (state_q == PKT);
  assign can_accept   = ~out_valid_q | out_ready;
  assign load         = in_pkt & owner_valid & can_accept;
  assign grant_multi  = |(grant & (grant - N'(1)));
  assign grant_onehot = (grant != '0) && !grant_multi;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant_err_d = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        grant_err_d = grant_multi;
        if (grant_onehot && ((grant & in_valid) != '0)) begin
          owner_d = grant;
          state_d = PKT;
        end
      end
      PKT: begin
        // Grant is ignored here, so a grant seen in the last-beat cycle is not captured.
        if (load && owner_last) begin
          owner_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = owner_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign in_ready  = owner_q & {N{in_pkt & can_accept}};
  assign request   = in_valid;
  assign lock      = owner_q & {N{in_pkt}};
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign owner     = owner_q;
  assign busy      = in_pkt;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_kw_arb_grant_mux.sv
// Scoreboard bench for kw_arb_grant_mux: per-client source queues, a static-priority
// arbiter model with lock, and a monitor that pops expected beats on each output handshake.
module tb_kw_arb_grant_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic           clock;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   request;
  logic [N-1:0]   lock;
  logic [N-1:0]   grant;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [N-1:0]   owner;
  logic           busy;
  logic           grant_err;

  typedef logic [W:0] beat_t;   // {last, data}

  beat_t       src_q [N][$];
  beat_t       exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        arb_en;
  logic [N-1:0] grant_force;
  logic [N-1:0] neg_req;

  kw_arb_grant_mux #(.N(N), .WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .request(request), .lock(lock), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .owner(owner), .busy(busy), .grant_err(grant_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Static-priority arbiter model: stays on the locked owner while it requests.
  always_comb begin
    grant   = '0;
    neg_req = ~request + 4'd1;
    if (!arb_en) grant = grant_force;
    else if ((lock & request) != '0) grant = lock & request;
    else grant = request & neg_req;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic bit src_pending();
    bit p = 0;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic push_pkt(input int client, input logic [W-1:0] base, input int beats);
    for (int k = 0; k < beats; k++) begin
      beat_t b;
      b = {(k == beats - 1) ? 1'b1 : 1'b0, base + W'(k)};
      src_q[client].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || src_pending() || busy || out_valid) && k < budget) begin
      step();
      k++;
    end
    chk(name, 64'(k < budget), 64'd1);
  endtask

  // Source driver: pops a beat after each observed handshake, then re-presents the queue head.
  initial begin
    logic [N-1:0] fire;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    forever begin
      @(negedge clock);
      fire = reset ? '0 : (in_valid & in_ready);
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          in_valid[i]          = 1'b1;
          in_data[i*W +: W]    = src_q[i][0][W-1:0];
          in_last[i]           = src_q[i][0][W];
        end else begin
          in_valid[i]          = 1'b0;
          in_data[i*W +: W]    = '0;
          in_last[i]           = 1'b0;
        end
      end
    end
  end

  // Output monitor: one line per accepted output beat, compared against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h last %0b, required no beat", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          $display("beat data=%08h last=%0b t=%0t", out_data, out_last, $time);
          chk("out_beat", {31'd0, out_last, out_data}, {31'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d1;
    int k;
    reset       = 1'b1;
    out_ready   = 1'b1;
    arb_en      = 1'b1;
    grant_force = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_grant_err", 64'(grant_err), 64'd0);
    chk("rst_lock", 64'(lock), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);

    // Single 3-beat packet from client 2
    push_pkt(2, 32'hA000_0000, 3);
    step();                                   // t0
    chk("t1_request", 64'(request), 64'h4);
    chk("t1_owner_t0", 64'(owner), 64'h0);
    step();                                   // t0+1
    chk("t1_owner", 64'(owner), 64'h4);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_lock", 64'(lock), 64'h4);
    chk("t1_in_ready", 64'(in_ready), 64'h4);
    chk("t1_out_valid_t1", 64'(out_valid), 64'd0);
    step();                                   // t0+2
    chk("t1_out_valid_t2", 64'(out_valid), 64'd1);
    chk("t1_out_last_t2", 64'(out_last), 64'd0);
    step();                                   // t0+3
    step();                                   // t0+4
    chk("t1_busy_t4", 64'(busy), 64'd0);
    chk("t1_out_last_t4", 64'(out_last), 64'd1);
    chk("t1_lock_t4", 64'(lock), 64'h0);
    drain("t1_drain", 50);

    // Contention: clients 0 and 1, 2-beat packets; client 0 wins and keeps the lock
    push_pkt(0, 32'hB000_0000, 2);
    push_pkt(1, 32'hC000_0000, 2);
    step();                                   // t0
    step();                                   // t0+1
    chk("t2_lock_t1", 64'(lock), 64'h1);
    step();                                   // t0+2
    chk("t2_lock_t2", 64'(lock), 64'h1);
    chk("t2_in_ready_t2", 64'(in_ready), 64'h1);
    step();                                   // t0+3: IDLE capture cycle
    chk("t2_busy_t3", 64'(busy), 64'd0);
    chk("t2_owner_t3", 64'(owner), 64'h0);
    step();                                   // t0+4
    chk("t2_owner_t4", 64'(owner), 64'h2);
    chk("t2_lock_t4", 64'(lock), 64'h2);
    drain("t2_drain", 50);

    // Back-pressure mid-packet: client 3, 5 beats, out_ready low for 3 cycles
    push_pkt(3, 32'hD000_0000, 5);
    d1 = 32'hD000_0001;
    step();                                   // t0
    step();                                   // t0+1
    step();                                   // t0+2: D0 on output
    @(posedge clock); #2; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_hold_data", 64'(out_data), 64'(d1));
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_in_ready", 64'(in_ready), 64'h0);
      chk("t3_busy", 64'(busy), 64'd1);
    end
    @(posedge clock); #2; out_ready = 1'b1;
    drain("t3_drain", 50);

    // Bad grant in IDLE, then one-hot grant to a non-valid client
    arb_en = 1'b0;
    @(posedge clock); #2; grant_force = 4'b0110;
    step();
    chk("t4_err_c0", 64'(grant_err), 64'd0);
    @(posedge clock); #2; grant_force = 4'b0000;
    step();
    chk("t4_err_c1", 64'(grant_err), 64'd1);
    chk("t4_owner", 64'(owner), 64'h0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'h0);
    step();
    chk("t4_err_c2", 64'(grant_err), 64'd0);
    @(posedge clock); #2; grant_force = 4'b1000;
    step();
    @(posedge clock); #2; grant_force = 4'b0000;
    step();
    chk("t4_nonvalid_busy", 64'(busy), 64'd0);
    chk("t4_nonvalid_err", 64'(grant_err), 64'd0);
    arb_en = 1'b1;

    // Reset mid-packet: client 1, 4 beats
    push_pkt(1, 32'hE000_0000, 4);
    k = 0;
    while (!(out_valid && out_data == 32'hE000_0001) && k < 50) begin
      step();
      k++;
    end
    chk("t5_reach_beat2", 64'(k < 50), 64'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    step();
    step();
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_owner", 64'(owner), 64'h0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_lock", 64'(lock), 64'h0);
    reset = 1'b0;
    push_pkt(3, 32'hF000_0000, 2);
    step();                                   // t0
    step();                                   // t0+1
    chk("t5_restart_owner", 64'(owner), 64'h8);
    drain("t5_drain", 50);

    // Back-to-back single-beat packets: client 0 twice, then client 1
    push_pkt(0, 32'h1111_0000, 1);
    push_pkt(0, 32'h2222_0000, 1);
    push_pkt(1, 32'h3333_0000, 1);
    step();                                   // t0
    step();                                   // t0+1
    chk("t6_busy_t1", 64'(busy), 64'd1);
    chk("t6_owner_t1", 64'(owner), 64'h1);
    step();                                   // t0+2
    chk("t6_busy_t2", 64'(busy), 64'd0);
    chk("t6_out_valid_t2", 64'(out_valid), 64'd1);
    step();                                   // t0+3
    chk("t6_busy_t3", 64'(busy), 64'd1);
    chk("t6_out_valid_t3", 64'(out_valid), 64'd0);
    step();                                   // t0+4
    chk("t6_busy_t4", 64'(busy), 64'd0);
    step();                                   // t0+5
    chk("t6_busy_t5", 64'(busy), 64'd1);
    chk("t6_owner_t5", 64'(owner), 64'h2);
    step();                                   // t0+6
    chk("t6_busy_t6", 64'(busy), 64'd0);
    drain("t6_drain", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
